gnn_0_save_axi_wr_master: RTL and testbench
===========================================

// Module: gnn_0_save_axi_wr_master
// PURPOSE
// AXI4 write master of the save path. It consumes the 512-bit data stream produced by the save
// buffer-reader stage (tvalid/tready/tdata) and writes it to DRAM. A transfer is split into
// INCR bursts that never cross a 4 KB boundary, and completion is reported once every B response
// has returned. It sits between the save stream stage and the kernel's m_axi write port.
// PARAMETERS
// C_M_AXI_ADDR_WIDTH     64   AXI address width
// C_M_AXI_DATA_WIDTH     512  AXI data width; LP_DW_BYTES = width/8 = 64
// C_XFER_SIZE_WIDTH      32   transfer size field width (bytes)
// C_MAX_OUTSTANDING      32   max AW bursts issued without a B response
// LP_BURST_BEATS         4096/LP_DW_BYTES, capped at 256 (=64)   max beats per burst
// PORTS
// aclk              in   1     clock
// areset            in   1     reset, asynchronous, active-high
// ctrl_start        in   1     1-cycle pulse; samples ctrl_addr/ctrl_size (honoured in IDLE only)
// ctrl_addr         in   AW    DRAM byte start address, 64 B aligned
// ctrl_size         in   XS    transfer bytes, multiple of 64 (0 allowed)
// ctrl_done         out  1     1-cycle pulse when transfer complete
// s_axis_tvalid     in   1     stream beat valid (from save stage)
// s_axis_tready     out  1     stream beat accept
// s_axis_tdata      in   DW    stream beat data
// m_axi_awvalid/awready  out/in  1    AW handshake
// m_axi_awaddr      out  AW    burst start address
// m_axi_awlen       out  8     beats-1
// m_axi_wvalid/wready    out/in  1    W handshake
// m_axi_wdata       out  DW    = s_axis_tdata (combinational pass-through)
// m_axi_wstrb       out  DW/8  all ones
// m_axi_wlast       out  1     last beat of current W burst
// m_axi_bvalid/bready    in/out  1    B handshake
// BEHAVIOUR
// Reset: FSM=IDLE; awvalid, wvalid, s_axis_tready, ctrl_done=0; bready=1; all counters 0.
// FSM IDLE -> (ctrl_start) RUN -> (all W beats sent && all B received) DONE -> IDLE next cycle.
//   DONE asserts ctrl_done for exactly one cycle. ctrl_start outside IDLE is ignored.
//   ctrl_size==0: IDLE->RUN->DONE, no AXI traffic, ctrl_done 2 cycles after ctrl_start.
// Burst split (AW and W use identical independent calculators): beats_left = size/64;
//   burst = min(beats_left, LP_BURST_BEATS, (4096 - addr[11:0])/64); addr += burst*64.
// AW: awvalid held with stable addr/len until awready. Next burst's AW issues the cycle after
//   the handshake if bursts remain and outstanding < C_MAX_OUTSTANDING.
// outstanding: +1 on AW handshake, -1 on B handshake (bvalid&&bready); both in one cycle -> unchanged.
// W: in RUN with W beats remaining, wvalid = s_axis_tvalid, s_axis_tready = m_axi_wready;
//   zero added latency, no buffering. W may lead AW (AXI-legal). wlast on the final beat of each
//   W burst; the W beat counter reloads on the wlast handshake. All W beats sent -> tready=0.
// B: bready=1 in all states out of reset; bresp is not checked.
// Done condition: W beats remaining==0 && B responses received == bursts issued == total bursts.
// Address arithmetic in C_M_AXI_ADDR_WIDTH bits, no wrap check; beat counters XS-6 bits.
// areset mid-transfer: all state returns to reset values immediately; in-flight AXI
//   transactions are abandoned (interconnect is reset alongside).
// TESTING
// 1: addr=0x0, size=4096, tvalid=1, ready=1 -> one AW len=63, 64 W beats, wlast on beat 64, one done pulse.
// 2: addr=0xFC0, size=256 -> AW0 addr=0xFC0 len=0; AW1 addr=0x1000 len=2; wlast on beats 1 and 4.
// 3: size=64*64*40, awready=1, bvalid held 0 -> exactly 32 AWs issued, 33rd only after first B.
// 4: random wready/tvalid/awready stalls, size=20000B rounded to 19968 -> data order preserved, beat count 312.
// 5: size=0 -> no awvalid/wvalid ever, ctrl_done 2 cycles after ctrl_start.
// 6: areset asserted mid-burst -> outputs at reset values same edge; new ctrl_start runs cleanly.

Source files
------------

// File: rtl/gnn_0_save_axi_wr_master.sv
// AXI4 write master for the save path: streams 512-bit beats to DRAM as INCR bursts
// that never cross a 4 KB page, and pulses ctrl_done once every B response is back.
module gnn_0_save_axi_wr_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_OUTSTANDING  = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_size,
  output logic                            ctrl_done,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int LP_DW_BYTES    = C_M_AXI_DATA_WIDTH / 8;
  localparam int LOG            = $clog2(LP_DW_BYTES);
  localparam int LP_PAGE_BEATS  = 4096 / LP_DW_BYTES;
  localparam int LP_BURST_BEATS = (LP_PAGE_BEATS > 256) ? 256 : LP_PAGE_BEATS;
  localparam int BW             = C_XFER_SIZE_WIDTH - LOG;
  localparam int LW             = $clog2(LP_BURST_BEATS + 1);
  localparam int OW             = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int AW             = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] aw_addr_q, awaddr_q, w_addr_q;
  logic [BW-1:0] aw_left_q, w_left_q;
  logic [LW-1:0] w_idx_q, aw_cur, w_cur;
  logic [OW-1:0] outstanding_q, out_nxt;
  logic          awvalid_q, aw_hs, b_hs, aw_issue, w_active, w_hs, wlast, done_cond;
  logic [7:0]    awlen_q;
  logic          unused_size_lsbs;

  assign unused_size_lsbs = ^ctrl_size[LOG-1:0];

  // Beats in the next burst: bounded by remaining beats, max burst and the 4 KB page end.
  function automatic logic [LW-1:0] burst_len(input logic [11-LOG:0] page_off,
                                              input logic [BW-1:0] left);
    logic [12:0] to_page;
    logic [12:0] n;
    to_page = 13'(LP_PAGE_BEATS) - 13'(page_off);
    n       = 13'(LP_BURST_BEATS);
    if (to_page < n) n = to_page;
    if (32'(left) < 32'(n)) n = 13'(left);
    return LW'(n);
  endfunction

  assign aw_cur = burst_len(aw_addr_q[11:LOG], aw_left_q);
  assign w_cur  = burst_len(w_addr_q[11:LOG], w_left_q);

  assign aw_hs     = awvalid_q & m_axi_awready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign w_active  = (state == S_RUN) && (w_left_q != '0);
  assign wlast     = w_active && (w_idx_q == w_cur - LW'(1));
  assign w_hs      = w_active && s_axis_tvalid && m_axi_wready;
  assign done_cond = (w_left_q == '0) && (aw_left_q == '0) && !awvalid_q && (outstanding_q == '0);

  always_comb begin
    out_nxt = outstanding_q;
    if (aw_hs) out_nxt = out_nxt + OW'(1);
    if (b_hs && (outstanding_q != '0)) out_nxt = out_nxt - OW'(1);
  end

  // The next AW may be loaded on the same edge the current one handshakes.
  assign aw_issue = (state == S_RUN) && (!awvalid_q || aw_hs) && (aw_left_q != '0) &&
                    (out_nxt < OW'(C_MAX_OUTSTANDING));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (ctrl_start) state_nxt = S_RUN;
      S_RUN:   if (done_cond)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      aw_addr_q     <= '0;
      aw_left_q     <= '0;
      w_addr_q      <= '0;
      w_left_q      <= '0;
      w_idx_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state         <= state_nxt;
      outstanding_q <= out_nxt;
      if (state == S_IDLE && ctrl_start) begin
        aw_addr_q <= ctrl_addr;
        aw_left_q <= ctrl_size[C_XFER_SIZE_WIDTH-1:LOG];
        w_addr_q  <= ctrl_addr;
        w_left_q  <= ctrl_size[C_XFER_SIZE_WIDTH-1:LOG];
        w_idx_q   <= '0;
      end else begin
        if (aw_issue) begin
          awvalid_q <= 1'b1;
          awaddr_q  <= aw_addr_q;
          awlen_q   <= 8'(aw_cur - LW'(1));
          aw_addr_q <= aw_addr_q + (AW'(aw_cur) << LOG);
          aw_left_q <= aw_left_q - BW'(aw_cur);
        end else if (aw_hs) begin
          awvalid_q <= 1'b0;
        end
        if (w_hs) begin
          if (wlast) begin
            w_addr_q <= w_addr_q + (AW'(w_cur) << LOG);
            w_left_q <= w_left_q - BW'(w_cur);
            w_idx_q  <= '0;
          end else begin
            w_idx_q  <= w_idx_q + LW'(1);
          end
        end
      end
    end
  end

  assign ctrl_done     = (state == S_DONE);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_wvalid  = w_active & s_axis_tvalid;
  assign s_axis_tready = w_active & m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast;
  assign m_axi_bready  = 1'b1;

endmodule

// File: tb/tb_gnn_0_save_axi_wr_master.sv
// Scoreboard bench for gnn_0_save_axi_wr_master: stimulus queues expected AW/W/done
// events, a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_gnn_0_save_axi_wr_master;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XS = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr = '0;
  logic [XS-1:0] ctrl_size = '0;
  logic          ctrl_done;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic          m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready;

  gnn_0_save_axi_wr_master #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .C_XFER_SIZE_WIDTH(XS), .C_MAX_OUTSTANDING(32)
  ) dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_size(ctrl_size), .ctrl_done(ctrl_done), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] q_aw_addr[$];
  logic [7:0]    q_aw_len[$];
  logic [DW-1:0] q_w_data[$];
  logic          q_w_last[$];
  int            q_done[$];
  int aw_hs_cnt = 0, w_hs_cnt = 0, done_cnt = 0, b_taken = 0, src_idx = 0;
  bit stall = 1'b0;
  bit b_en = 1'b1;

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < DW / 32; j++)
      d[j*32 +: 32] = (32'(i) * 32'h9E37_79B1) ^ (32'(j) * 32'h0101_0101) ^ 32'hA5A5_0000;
    return d;
  endfunction

  // Reference split: walk beat by beat, closing a burst at 64 beats, a 4 KB page end or the last beat.
  task automatic push_expect(input logic [AW-1:0] addr, input logic [XS-1:0] size);
    int beats;
    int cnt;
    int base;
    logic [AW-1:0] a;
    logic [AW-1:0] bs;
    logic last;
    beats = int'(size >> 6);
    base  = src_idx;
    a     = addr;
    bs    = addr;
    cnt   = 0;
    for (int i = 0; i < beats; i++) begin
      cnt++;
      a = a + 64'd64;
      last = (cnt == 64) || (a[11:0] == 12'h000) || (i == beats - 1);
      q_w_data.push_back(pat(base + i));
      q_w_last.push_back(last);
      if (last) begin
        q_aw_addr.push_back(bs);
        q_aw_len.push_back(8'(cnt - 1));
        bs  = a;
        cnt = 0;
      end
    end
    q_done.push_back(1);
  endtask

  task automatic start_xfer(input logic [AW-1:0] addr, input logic [XS-1:0] size);
    push_expect(addr, size);
    @(posedge aclk); #1;
    ctrl_addr  = addr;
    ctrl_size  = size;
    ctrl_start = 1'b1;
    @(posedge aclk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input int limit, input string nm);
    int n;
    n = 0;
    while (done_cnt < tgt && n < limit) begin
      @(negedge aclk);
      n++;
    end
    chk(nm, DW'(done_cnt), DW'(tgt));
  endtask

  // Stream source and AXI ready drivers; data advances only on an accepted beat.
  initial begin
    logic hs;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pat(0);
    m_axi_wready  = 1'b1;
    m_axi_awready = 1'b1;
    forever begin
      @(posedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      #1;
      if (hs) src_idx++;
      s_axis_tdata  = pat(src_idx);
      s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_axi_awready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  // B responder: one response per accepted AW, gated by b_en.
  initial begin
    logic hs;
    m_axi_bvalid = 1'b0;
    forever begin
      @(posedge aclk);
      hs = m_axi_bvalid && m_axi_bready;
      #1;
      if (areset) begin
        b_taken      = aw_hs_cnt;
        m_axi_bvalid = 1'b0;
      end else begin
        if (hs) b_taken++;
        m_axi_bvalid = b_en && (aw_hs_cnt > b_taken);
      end
    end
  end

  always @(negedge aclk) begin
    if (areset) begin
      q_aw_addr.delete();
      q_aw_len.delete();
      q_w_data.delete();
      q_w_last.delete();
      q_done.delete();
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_outstanding_limit", DW'((aw_hs_cnt - b_taken) < 32), DW'(1));
        if (q_aw_addr.size() == 0) chk("aw_unexpected", DW'(1), DW'(0));
        else begin
          chk("awaddr", DW'(m_axi_awaddr), DW'(q_aw_addr.pop_front()));
          chk("awlen", DW'(m_axi_awlen), DW'(q_aw_len.pop_front()));
        end
        aw_hs_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (q_w_data.size() == 0) chk("w_unexpected", DW'(1), DW'(0));
        else begin
          chk("wdata", m_axi_wdata, q_w_data.pop_front());
          chk("wlast", DW'(m_axi_wlast), DW'(q_w_last.pop_front()));
          chk("wstrb", DW'(m_axi_wstrb), DW'({(DW/8){1'b1}}));
        end
        w_hs_cnt++;
      end
      if (ctrl_done) begin
        if (q_done.size() == 0) chk("done_unexpected", DW'(1), DW'(0));
        else void'(q_done.pop_front());
        chk("done_aw_drained", DW'(q_aw_addr.size()), DW'(0));
        chk("done_w_drained", DW'(q_w_data.size()), DW'(0));
        chk("done_all_b", DW'(b_taken), DW'(aw_hs_cnt));
        done_cnt++;
      end
    end
  end

  initial begin
    int base_aw;
    int base_w;
    #12;
    chk("rst_awvalid", DW'(m_axi_awvalid), DW'(0));
    chk("rst_wvalid", DW'(m_axi_wvalid), DW'(0));
    chk("rst_tready", DW'(s_axis_tready), DW'(0));
    chk("rst_done", DW'(ctrl_done), DW'(0));
    chk("rst_bready", DW'(m_axi_bready), DW'(1));
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    // single full page burst
    start_xfer(64'h0, 32'd4096);
    wait_done(1, 500, "t1_done");

    // page-crossing split 1 + 3 beats
    start_xfer(64'hFC0, 32'd256);
    wait_done(2, 500, "t2_done");

    // outstanding cap with B withheld
    b_en    = 1'b0;
    base_aw = aw_hs_cnt;
    start_xfer(64'h0, 32'(64 * 64 * 40));
    repeat (300) @(negedge aclk);
    chk("t3_aw_capped", DW'(aw_hs_cnt - base_aw), DW'(32));
    chk("t3_no_33rd_awvalid", DW'(m_axi_awvalid), DW'(0));
    b_en = 1'b1;
    wait_done(3, 10000, "t3_done");
    chk("t3_aw_total", DW'(aw_hs_cnt - base_aw), DW'(40));

    // random stalls, 312 beats crossing several pages
    stall  = 1'b1;
    base_w = w_hs_cnt;
    start_xfer(64'h1_0000_0F00, 32'd19968);
    wait_done(4, 5000, "t4_done");
    chk("t4_beats", DW'(w_hs_cnt - base_w), DW'(312));
    stall = 1'b0;

    // zero-size transfer
    base_aw = aw_hs_cnt;
    base_w  = w_hs_cnt;
    start_xfer(64'h4000, 32'd0);
    @(negedge aclk);
    chk("t5_done_cycle1", DW'(ctrl_done), DW'(0));
    @(negedge aclk);
    chk("t5_done_cycle2", DW'(ctrl_done), DW'(1));
    @(negedge aclk);
    chk("t5_done_one_cycle", DW'(ctrl_done), DW'(0));
    chk("t5_no_aw", DW'(aw_hs_cnt - base_aw), DW'(0));
    chk("t5_no_w", DW'(w_hs_cnt - base_w), DW'(0));

    // reset mid-burst, then a clean transfer
    start_xfer(64'h3000, 32'd4096);
    repeat (20) @(negedge aclk);
    chk("t6_pre_wvalid", DW'(m_axi_wvalid), DW'(1));
    areset = 1'b1;
    #1;
    chk("t6_awvalid", DW'(m_axi_awvalid), DW'(0));
    chk("t6_wvalid", DW'(m_axi_wvalid), DW'(0));
    chk("t6_tready", DW'(s_axis_tready), DW'(0));
    chk("t6_done", DW'(ctrl_done), DW'(0));
    chk("t6_bready", DW'(m_axi_bready), DW'(1));
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    start_xfer(64'h2000_0040, 32'd8192);
    wait_done(6, 1000, "t6_clean_done");

    repeat (5) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
